// File: rtl/umi_mem_endpoint.sv
// UMI memory endpoint: word RAM plus EXIT/PUTC registers, one read response in flight.
// Define PERF_CNT_EN to add a free-running cycle counter readable at PERF_ADDR.
module umi_mem_endpoint #(
    parameter int          AW        = 10,
    parameter logic [31:0] EXIT_ADDR = 32'h1000_0000,
    parameter logic [31:0] PUTC_ADDR = 32'h1000_0008,
    parameter logic [31:0] PERF_ADDR = 32'h1000_0010
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [255:0] umi_packet_rx,
    input  logic         umi_valid_rx,
    output logic         umi_ready_rx,
    output logic [255:0] umi_packet_tx,
    output logic         umi_valid_tx,
    input  logic         umi_ready_tx,
    output logic         trap,
    output logic         trace_valid,
    output logic [31:0]  trace_data
);
    localparam logic [7:0]  CMD_WRITE = 8'h01;
    localparam logic [7:0]  CMD_READ  = 8'h02;
    localparam logic [7:0]  CMD_RESP  = 8'h03;
    localparam logic [31:0] RAM_LIMIT = 32'd4 << AW;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [7:0]    cmd;
    logic [31:0]   dst, src, wdata, rdata;
    logic [AW-1:0] idx;
    logic          accept, hit, is_wr, is_rd;
    logic [255:0]  resp;

    assign cmd    = umi_packet_rx[7:0];
    assign dst    = umi_packet_rx[95:64];
    assign src    = umi_packet_rx[159:128];
    assign wdata  = umi_packet_rx[191:160];
    assign idx    = dst[AW+1:2];
    assign hit    = dst < RAM_LIMIT;

    // Ready never looks at valid_rx, so the upstream queue sees no combinational loop.
    assign umi_ready_rx = !umi_valid_tx || umi_ready_tx;
    assign accept       = umi_valid_rx && umi_ready_rx;
    assign is_wr        = accept && (cmd == CMD_WRITE);
    assign is_rd        = accept && (cmd == CMD_READ);

`ifdef PERF_CNT_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) perf_cnt <= '0;
        else         perf_cnt <= perf_cnt + 32'd1;
    end

    logic unused_ok;
    assign unused_ok = ^{umi_packet_rx[63:8], umi_packet_rx[127:96], umi_packet_rx[255:192]};
`else
    logic unused_ok;
    assign unused_ok = ^{umi_packet_rx[63:8], umi_packet_rx[127:96], umi_packet_rx[255:192], PERF_ADDR};
`endif

    always_comb begin
        rdata = 32'hDEAD_BEEF;
        if (hit)                                      rdata = mem[idx];
        else if (dst == EXIT_ADDR || dst == PUTC_ADDR) rdata = '0;
`ifdef PERF_CNT_EN
        else if (dst == PERF_ADDR)                     rdata = perf_cnt;
`endif
    end

    always_comb begin
        resp          = '0;
        resp[7:0]     = CMD_RESP;
        resp[95:64]   = src;
        resp[159:128] = dst;
        resp[191:160] = rdata;
    end

    // RAM holds no reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (is_wr && hit) mem[idx] <= wdata;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            umi_valid_tx  <= 1'b0;
            umi_packet_tx <= '0;
        end else if (is_rd) begin
            umi_valid_tx  <= 1'b1;
            umi_packet_tx <= resp;
        end else if (umi_ready_tx) begin
            umi_valid_tx  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            trap        <= 1'b0;
            trace_valid <= 1'b0;
            trace_data  <= '0;
        end else begin
            trace_valid <= is_wr && (dst == PUTC_ADDR);
            if (is_wr && dst == EXIT_ADDR) trap <= 1'b1;
            if (is_wr && dst == PUTC_ADDR) trace_data <= wdata;
        end
    end
endmodule

// File: tb/tb_umi_mem_endpoint.sv
// Directed bench for umi_mem_endpoint: transaction-level model compared every cycle,
// plus literal expectations at key points.
module tb_umi_mem_endpoint;
    logic         clk = 1'b0;
    logic         nreset;
    logic [255:0] umi_packet_rx;
    logic         umi_valid_rx;
    logic         umi_ready_rx;
    logic [255:0] umi_packet_tx;
    logic         umi_valid_tx;
    logic         umi_ready_tx;
    logic         trap;
    logic         trace_valid;
    logic [31:0]  trace_data;

    umi_mem_endpoint dut (
        .clk(clk), .nreset(nreset),
        .umi_packet_rx(umi_packet_rx), .umi_valid_rx(umi_valid_rx), .umi_ready_rx(umi_ready_rx),
        .umi_packet_tx(umi_packet_tx), .umi_valid_tx(umi_valid_tx), .umi_ready_tx(umi_ready_tx),
        .trap(trap), .trace_valid(trace_valid), .trace_data(trace_data)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [255:0] mk(input logic [7:0] c, input logic [31:0] d,
                                        input logic [31:0] s, input logic [31:0] dat);
        // junk in the ignored fields
        return {64'hFEED_FACE_0BAD_C0DE, dat, s, 32'h5555_AAAA, d, 56'h12_3456_789A_BCDE, c};
    endfunction

    // ---------------- transaction-level model ----------------
    logic [31:0]  m_mem [int unsigned];
    bit           m_valid, m_trap, m_tv;
    logic [255:0] m_pkt;
    logic [31:0]  m_td, m_cnt;

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [31:0] cnt);
        if (a < 32'h1000)                          return m_mem.exists(a >> 2) ? m_mem[a >> 2] : 32'h0;
        if (a == 32'h1000_0000 || a == 32'h1000_0008) return 32'h0;
`ifdef PERF_CNT_EN
        if (a == 32'h1000_0010)                    return cnt;
`endif
        return 32'hDEAD_BEEF;
    endfunction

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_valid = 0; m_trap = 0; m_tv = 0; m_pkt = '0; m_td = '0; m_cnt = '0;
        end else begin
            logic [7:0]  c;
            logic [31:0] d, s, w;
            bit          acc;
            c = umi_packet_rx[7:0]; d = umi_packet_rx[95:64];
            s = umi_packet_rx[159:128]; w = umi_packet_rx[191:160];
            acc = umi_valid_rx && (!m_valid || umi_ready_tx);
            if (m_valid && umi_ready_tx) m_valid = 0;
            m_tv = 0;
            if (acc && c == 8'h02) begin
                m_valid = 1;
                m_pkt   = {64'h0, m_read(d, m_cnt), d, 32'h0, s, 56'h0, 8'h03};
            end
            if (acc && c == 8'h01) begin
                if (d < 32'h1000) m_mem[d >> 2] = w;
                if (d == 32'h1000_0000) m_trap = 1;
                if (d == 32'h1000_0008) begin m_tv = 1; m_td = w; end
            end
            m_cnt = m_cnt + 1;
        end
    end

    // single compare process against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready_rx",    {255'h0, umi_ready_rx}, {255'h0, !m_valid || umi_ready_tx});
            check("valid_tx",    {255'h0, umi_valid_tx}, {255'h0, m_valid});
            check("packet_tx",   umi_packet_tx, m_pkt);
            check("trap",        {255'h0, trap}, {255'h0, m_trap});
            check("trace_valid", {255'h0, trace_valid}, {255'h0, m_tv});
            check("trace_data",  {224'h0, trace_data}, {224'h0, m_td});
        end
    end

    // one request, accepted on the next edge (caller ensures ready)
    task automatic req(input logic [7:0] c, input logic [31:0] d, input logic [31:0] s, input logic [31:0] dat);
        umi_packet_rx = mk(c, d, s, dat);
        umi_valid_rx  = 1'b1;
        @(posedge clk); #1;
        umi_valid_rx  = 1'b0;
        umi_packet_rx = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] perf_a;

    initial begin
        nreset = 1'b1; umi_valid_rx = 1'b0; umi_packet_rx = '0; umi_ready_tx = 1'b1;
        #1 nreset = 1'b0;
        chk_en = 1'b1;
        idle(3);
        check("rst_valid_tx", {255'h0, umi_valid_tx}, 256'h0);
        check("rst_packet",   umi_packet_tx, 256'h0);
        check("rst_trap",     {255'h0, trap}, 256'h0);
        check("rst_ready_rx", {255'h0, umi_ready_rx}, 256'h1);
        nreset = 1'b1;
        idle(1);

        // write then read, literal response fields
        req(8'h01, 32'h4, 32'h0, 32'hCAFE_F00D);
        req(8'h02, 32'h4, 32'h200, 32'h0);
        check("rd_cmd",  {248'h0, umi_packet_tx[7:0]}, 256'h03);
        check("rd_dst",  {224'h0, umi_packet_tx[95:64]}, 256'h200);
        check("rd_src",  {224'h0, umi_packet_tx[159:128]}, 256'h4);
        check("rd_data", {224'h0, umi_packet_tx[191:160]}, 256'hCAFE_F00D);
        check("rd_zero", {64'h0, umi_packet_tx[255:192], umi_packet_tx[127:96], umi_packet_tx[63:8]}, 256'h0);
        idle(1);
        check("rd_once", {255'h0, umi_valid_tx}, 256'h0);

        // read-after-write back to back, byte offset ignored, last RAM word, first unmapped
        req(8'h01, 32'h10, 32'h0, 32'h1111_2222);
        req(8'h02, 32'h13, 32'h204, 32'h0);
        check("raw_data", {224'h0, umi_packet_tx[191:160]}, 256'h1111_2222);
        req(8'h01, 32'hFFC, 32'h0, 32'h7777_8888);
        req(8'h01, 32'h1000, 32'h0, 32'h9999_0000);
        req(8'h02, 32'hFFC, 32'h208, 32'h0);
        check("top_word", {224'h0, umi_packet_tx[191:160]}, 256'h7777_8888);
        req(8'h02, 32'h1000, 32'h20C, 32'h0);
        check("past_ram", {224'h0, umi_packet_tx[191:160]}, 256'hDEAD_BEEF);
        idle(1);

        // backpressure: response held, rx blocked, then new read accepted on the handshake edge
        umi_ready_tx = 1'b0;
        req(8'h02, 32'h4, 32'h300, 32'h0);
        umi_packet_rx = mk(8'h02, 32'h10, 32'h304, 32'h0);
        umi_valid_rx  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("bp_ready_rx", {255'h0, umi_ready_rx}, 256'h0);
            check("bp_hold",     {224'h0, umi_packet_tx[95:64]}, 256'h300);
        end
        umi_ready_tx = 1'b1;
        idle(1);
        umi_valid_rx = 1'b0; umi_packet_rx = '0;
        check("b2b_valid", {255'h0, umi_valid_tx}, 256'h1);
        check("b2b_dst",   {224'h0, umi_packet_tx[95:64]}, 256'h304);
        check("b2b_data",  {224'h0, umi_packet_tx[191:160]}, 256'h1111_2222);
        idle(1);

        // PUTC trace pulse
        req(8'h01, 32'h1000_0008, 32'h0, 32'h41);
        check("putc_tv", {255'h0, trace_valid}, 256'h1);
        check("putc_td", {224'h0, trace_data}, 256'h41);
        idle(1);
        check("putc_pulse", {255'h0, trace_valid}, 256'h0);
        check("putc_no_tx", {255'h0, umi_valid_tx}, 256'h0);

        // EXIT trap, sticky, reads still served
        req(8'h01, 32'h1000_0000, 32'h0, 32'h1);
        check("trap_set", {255'h0, trap}, 256'h1);
        idle(4);
        req(8'h02, 32'h1000_0000, 32'h400, 32'h0);
        check("trap_hold",  {255'h0, trap}, 256'h1);
        check("exit_rd",    {224'h0, umi_packet_tx[191:160]}, 256'h0);
        check("exit_rd_vl", {255'h0, umi_valid_tx}, 256'h1);

        // unmapped read and unknown command
        req(8'h02, 32'h2000_0000, 32'h404, 32'h0);
        check("unmapped", {224'h0, umi_packet_tx[191:160]}, 256'hDEAD_BEEF);
        req(8'h7F, 32'h4, 32'h0, 32'h99);
        check("bad_cmd_tx", {255'h0, umi_valid_tx}, 256'h0);
        req(8'h02, 32'h4, 32'h408, 32'h0);
        check("bad_cmd_ram", {224'h0, umi_packet_tx[191:160]}, 256'hCAFE_F00D);
        idle(1);

        // counter reads 10 cycles apart
        req(8'h02, 32'h1000_0010, 32'h500, 32'h0);
        perf_a = umi_packet_tx[191:160];
        idle(9);
        req(8'h02, 32'h1000_0010, 32'h504, 32'h0);
`ifdef PERF_CNT_EN
        check("perf_delta", {224'h0, umi_packet_tx[191:160] - perf_a}, 256'd10);
`else
        check("perf_off",   {224'h0, umi_packet_tx[191:160]}, 256'hDEAD_BEEF);
`endif
        idle(1);

        // reset with a response pending
        umi_ready_tx = 1'b0;
        req(8'h02, 32'h4, 32'h600, 32'h0);
        nreset = 1'b0;
        #1;
        check("rst_mid_valid", {255'h0, umi_valid_tx}, 256'h0);
        check("rst_mid_trap",  {255'h0, trap}, 256'h0);
        umi_ready_tx = 1'b1;
        idle(2);
        nreset = 1'b1;
        idle(2);
        req(8'h02, 32'hFFC, 32'h604, 32'h0);
        check("post_rst_ram", {224'h0, umi_packet_tx[191:160]}, 256'h7777_8888);
        idle(2);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
